// File: rtl/fetch_sequencer_if.sv
// ----------------------------------------------------------------------------
// fetch_sequencer_if
// Bundles the instruction-fetch sequencer's bus traffic: the instruction ROM
// side (address, benchmark select, read data), the IF-stage output toward
// decode (valid/instr/pc with ready back-pressure) and the branch redirect.
//
// Signals
//   imem_addr      64  byte address presented to the instruction ROM
//   imem_test_sel   4  benchmark select presented to the instruction ROM
//   imem_instr     32  combinational ROM read data for imem_addr
//   if_valid        1  if_instr/if_pc hold a fetched word
//   if_instr       32  fetched instruction
//   if_pc          64  address of if_instr
//   id_ready        1  decode accepts the word this cycle
//   redirect_valid  1  branch/flush request
//   redirect_pc    64  redirect target
//
// Modports
//   master : the fetch sequencer
//   slave  : the environment (ROM, decode stage, branch unit)
// ----------------------------------------------------------------------------
interface fetch_sequencer_if;
    logic [63:0] imem_addr;
    logic [3:0]  imem_test_sel;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        id_ready;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    modport master (
        output imem_addr,
        output imem_test_sel,
        input  imem_instr,
        output if_valid,
        output if_instr,
        output if_pc,
        input  id_ready,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  imem_addr,
        input  imem_test_sel,
        output imem_instr,
        input  if_valid,
        input  if_instr,
        input  if_pc,
        output id_ready,
        output redirect_valid,
        output redirect_pc
    );
endinterface

// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer
// Instruction-fetch controller. Owns the PC, drives the instruction ROM address
// and the latched benchmark select, and registers each fetched word into an
// IF-stage output with a valid/ready handshake toward decode. Handles decode
// stalls, branch-redirect flushes and halting at the end of instruction memory.
//
// Parameters
//   RESET_PC   PC loaded on reset release (word aligned)
//   MEM_BYTES  instruction ROM size in bytes (power of two, > 4)
//
// Ports
//   clk           in   clock, all state updates on rising edge
//   reset_n       in   asynchronous active-low reset
//   cfg_test_sel  in   benchmark select, sampled once in START
//   bus           --   fetch_sequencer_if.master (ROM, IF-stage, redirect)
//   halted        out  sequencer sits in HALT
//   err_misalign  out  sticky flag: a misaligned redirect target was seen
//   perf_fetches  out  words handed to decode
//   perf_stalls   out  cycles with a held word that decode refused
//
// Optional feature
//   FETCH_PERF_CNT_EN  when defined, builds the saturating performance
//                      counters; otherwise perf_fetches/perf_stalls are 0.
// ----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          MEM_BYTES = 1024
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [3:0]                cfg_test_sel,
    fetch_sequencer_if.master         bus,
    output logic                      halted,
    output logic                      err_misalign,
    output logic [31:0]               perf_fetches,
    output logic [31:0]               perf_stalls
);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [63:0] MEM_LIMIT = 64'(MEM_BYTES);

    // Force a byte address onto a 4-byte word boundary.
    function automatic logic [63:0] align_word(input logic [63:0] addr);
        return {addr[63:2], 2'b00};
    endfunction

    state_t      state_r;
    logic [63:0] pc_r;
    logic        if_valid_r;
    logic [31:0] if_instr_r;
    logic [63:0] if_pc_r;
    logic [3:0]  test_sel_r;
    logic        halted_r;
    logic        err_misalign_r;

    logic        load_s;
    logic        redirect_take_s;
    logic        at_end_s;
    logic        misaligned_s;
    logic [63:0] redirect_target_s;

    // The output register may be refilled when it is empty or being consumed.
    assign load_s            = !if_valid_r || bus.id_ready;
    // Redirects are meaningless before the benchmark select is latched.
    assign redirect_take_s   = bus.redirect_valid && (state_r != ST_START);
    // Last whole word must fit below MEM_BYTES; compare at full 64-bit width.
    assign at_end_s          = (pc_r + 64'd3) >= MEM_LIMIT;
    assign misaligned_s      = (bus.redirect_pc[1:0] != 2'b00);
    assign redirect_target_s = align_word(bus.redirect_pc);

    // Sequencer FSM: PC, IF-stage output register, select latch and status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= ST_START;
            pc_r           <= RESET_PC;
            if_valid_r     <= 1'b0;
            if_instr_r     <= 32'h0;
            if_pc_r        <= 64'h0;
            test_sel_r     <= 4'h0;
            halted_r       <= 1'b0;
            err_misalign_r <= 1'b0;
        end else begin
            case (state_r)
                ST_START: begin
                    test_sel_r <= cfg_test_sel;
                    state_r    <= ST_RUN;
                end
                ST_RUN: begin
                    if (redirect_take_s) begin
                        // Flush wins over a stall: the held word is dropped.
                        if_valid_r <= 1'b0;
                        pc_r       <= redirect_target_s;
                        if (misaligned_s) begin
                            err_misalign_r <= 1'b1;
                        end else begin
                            err_misalign_r <= err_misalign_r;
                        end
                    end else if (load_s) begin
                        if (at_end_s) begin
                            if_valid_r <= 1'b0;
                            halted_r   <= 1'b1;
                            state_r    <= ST_HALT;
                        end else begin
                            if_instr_r <= bus.imem_instr;
                            if_pc_r    <= pc_r;
                            if_valid_r <= 1'b1;
                            pc_r       <= pc_r + 64'd4;
                        end
                    end else begin
                        // Stall: everything holds so no word is lost or duplicated.
                        pc_r <= pc_r;
                    end
                end
                ST_HALT: begin
                    if (redirect_take_s) begin
                        pc_r     <= redirect_target_s;
                        halted_r <= 1'b0;
                        state_r  <= ST_RUN;
                        if (misaligned_s) begin
                            err_misalign_r <= 1'b1;
                        end else begin
                            err_misalign_r <= err_misalign_r;
                        end
                    end else begin
                        if_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_START;
                    if_valid_r <= 1'b0;
                    halted_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_addr     = pc_r;
    assign bus.imem_test_sel = test_sel_r;
    assign bus.if_valid      = if_valid_r;
    assign bus.if_instr      = if_instr_r;
    assign bus.if_pc         = if_pc_r;
    assign halted            = halted_r;
    assign err_misalign      = err_misalign_r;

`ifdef FETCH_PERF_CNT_EN
    logic        transfer_s;
    logic        stall_s;
    logic [31:0] perf_fetches_r;
    logic [31:0] perf_stalls_r;

    assign transfer_s = if_valid_r && bus.id_ready;
    // A cycle spent flushing is not counted as a stall.
    assign stall_s    = if_valid_r && !bus.id_ready && !bus.redirect_valid;

    // Saturating performance counters, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetches_r <= 32'h0;
            perf_stalls_r  <= 32'h0;
        end else begin
            if (transfer_s && (perf_fetches_r != 32'hFFFF_FFFF)) begin
                perf_fetches_r <= perf_fetches_r + 32'd1;
            end else begin
                perf_fetches_r <= perf_fetches_r;
            end
            if (stall_s && (perf_stalls_r != 32'hFFFF_FFFF)) begin
                perf_stalls_r <= perf_stalls_r + 32'd1;
            end else begin
                perf_stalls_r <= perf_stalls_r;
            end
        end
    end

    assign perf_fetches = perf_fetches_r;
    assign perf_stalls  = perf_stalls_r;
`else
    assign perf_fetches = 32'h0;
    assign perf_stalls  = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fetch_sequencer
// Self-checking bench for fetch_sequencer. A behavioural ROM answers the
// address combinationally; expected handed-over PCs are queued as stimulus is
// driven and compared against the words decode actually accepts.
// Inputs change and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic        clk;
    logic        reset_n;
    logic [3:0]  cfg_test_sel;
    logic        halted;
    logic        err_misalign;
    logic [31:0] perf_fetches;
    logic [31:0] perf_stalls;

    fetch_sequencer_if bus ();

    fetch_sequencer #(
        .RESET_PC  (64'h0),
        .MEM_BYTES (1024)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cfg_test_sel (cfg_test_sel),
        .bus          (bus.master),
        .halted       (halted),
        .err_misalign (err_misalign),
        .perf_fetches (perf_fetches),
        .perf_stalls  (perf_stalls)
    );

    int checks;
    int errors;
    int exp_fetches;
    int exp_stalls;

    logic [63:0] exp_pc_q[$];
    logic [63:0] obs_pc_q[$];
    logic [31:0] obs_instr_q[$];

    // ROM contents depend on address and benchmark select.
    function automatic logic [31:0] rom_word(input logic [63:0] addr, input logic [3:0] sel);
        return {sel, addr[27:0]} ^ 32'h0BAD_F00D;
    endfunction

    assign bus.imem_instr = rom_word(bus.imem_addr, bus.imem_test_sel);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record any handover at this sample point, then advance one clock.
    task automatic cycle();
        if (bus.if_valid === 1'b1 && bus.id_ready === 1'b1) begin
            obs_pc_q.push_back(bus.if_pc);
            obs_instr_q.push_back(bus.if_instr);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_word(input logic [63:0] pc);
        exp_pc_q.push_back(pc);
        exp_fetches++;
    endtask

    task automatic test_reset();
        logic [31:0] zero_perf;
        zero_perf            = 32'h0;
        reset_n              = 1'b0;
        cfg_test_sel         = 4'd3;
        bus.id_ready         = 1'b1;
        bus.redirect_valid   = 1'b1;
        bus.redirect_pc      = 64'h81;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.if_valid !== 1'b0 || bus.if_pc !== 64'h0 || bus.if_instr !== 32'h0) begin
            errors++;
            $display("FAIL reset_if got v=%b pc=%h instr=%h exp 0/0/0", bus.if_valid, bus.if_pc, bus.if_instr);
        end
        checks++;
        if (bus.imem_addr !== 64'h0 || bus.imem_test_sel !== 4'h0) begin
            errors++;
            $display("FAIL reset_imem got addr=%h sel=%h exp 0/0", bus.imem_addr, bus.imem_test_sel);
        end
        checks++;
        if (halted !== 1'b0 || err_misalign !== 1'b0 || perf_fetches !== zero_perf || perf_stalls !== zero_perf) begin
            errors++;
            $display("FAIL reset_status got h=%b e=%b pf=%0d ps=%0d exp all 0", halted, err_misalign, perf_fetches, perf_stalls);
        end
        // Release into START with a redirect pending: it must be ignored.
        reset_n = 1'b1;
        cycle();
        checks++;
        if (bus.imem_test_sel !== 4'd3) begin
            errors++;
            $display("FAIL start_sel got %h exp 3", bus.imem_test_sel);
        end
        checks++;
        if (bus.imem_addr !== 64'h0 || err_misalign !== 1'b0 || bus.if_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_redirect_ignored got addr=%h e=%b v=%b exp 0/0/0", bus.imem_addr, err_misalign, bus.if_valid);
        end
        bus.redirect_valid = 1'b0;
    endtask

    task automatic test_stream();
        logic [63:0] e;
        logic [63:0] o;
        logic [31:0] oi;
        cycle();
        checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'h0 || bus.if_instr !== rom_word(64'h0, 4'd3)) begin
            errors++;
            $display("FAIL first_fetch got v=%b pc=%h instr=%h exp 1/0/%h", bus.if_valid, bus.if_pc, bus.if_instr, rom_word(64'h0, 4'd3));
        end
        expect_word(64'h0);
        cycle();
        expect_word(64'h4);
        cycle();
        // Select changes after START must have no effect.
        cfg_test_sel = 4'd9;
        bus.id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            exp_stalls++;
            checks++;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'h8 || bus.if_instr !== rom_word(64'h8, 4'd3) || bus.imem_addr !== 64'hC) begin
                errors++;
                $display("FAIL stall_hold got v=%b pc=%h instr=%h addr=%h exp 1/8/%h/c", bus.if_valid, bus.if_pc, bus.if_instr, bus.imem_addr, rom_word(64'h8, 4'd3));
            end
        end
        bus.id_ready = 1'b1;
        expect_word(64'h8);
        cycle();
        checks++;
        if (bus.if_pc !== 64'hC || bus.if_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_resume got v=%b pc=%h exp 1/c", bus.if_valid, bus.if_pc);
        end
        expect_word(64'hC);
        cycle();
        expect_word(64'h10);
        cycle();
        checks++;
        if (obs_pc_q.size() != exp_pc_q.size()) begin
            errors++;
            $display("FAIL stream_count got %0d exp %0d", obs_pc_q.size(), exp_pc_q.size());
        end
        while (exp_pc_q.size() > 0 && obs_pc_q.size() > 0) begin
            e = exp_pc_q.pop_front();
            o = obs_pc_q.pop_front();
            oi = obs_instr_q.pop_front();
            checks++;
            if (o !== e || oi !== rom_word(e, 4'd3)) begin
                errors++;
                $display("FAIL stream_word got pc=%h instr=%h exp pc=%h instr=%h", o, oi, e, rom_word(e, 4'd3));
            end
        end
        exp_pc_q.delete(); obs_pc_q.delete(); obs_instr_q.delete();
    endtask

    task automatic test_redirect();
        logic [63:0] e;
        logic [63:0] o;
        logic [31:0] oi;
        // Word at 0x14 held by a stall, then flushed by a redirect.
        bus.id_ready = 1'b0;
        cycle();
        exp_stalls++;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h40;
        cycle();
        bus.redirect_valid = 1'b0;
        bus.id_ready       = 1'b1;
        checks++;
        if (bus.if_valid !== 1'b0 || bus.imem_addr !== 64'h40) begin
            errors++;
            $display("FAIL redirect_flush got v=%b addr=%h exp 0/40", bus.if_valid, bus.imem_addr);
        end
        cycle();
        checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'h40 || bus.if_instr !== rom_word(64'h40, 4'd3)) begin
            errors++;
            $display("FAIL redirect_target got v=%b pc=%h instr=%h exp 1/40/%h", bus.if_valid, bus.if_pc, bus.if_instr, rom_word(64'h40, 4'd3));
        end
        expect_word(64'h40);
        cycle();
        expect_word(64'h44);
        cycle();
        checks++;
        if (obs_pc_q.size() != exp_pc_q.size()) begin
            errors++;
            $display("FAIL redirect_count got %0d exp %0d", obs_pc_q.size(), exp_pc_q.size());
        end
        while (exp_pc_q.size() > 0 && obs_pc_q.size() > 0) begin
            e = exp_pc_q.pop_front();
            o = obs_pc_q.pop_front();
            oi = obs_instr_q.pop_front();
            checks++;
            if (o !== e || oi !== rom_word(e, 4'd3)) begin
                errors++;
                $display("FAIL redirect_word got pc=%h instr=%h exp pc=%h instr=%h", o, oi, e, rom_word(e, 4'd3));
            end
        end
        exp_pc_q.delete(); obs_pc_q.delete(); obs_instr_q.delete();
    endtask

    task automatic test_halt();
        logic [63:0] e;
        logic [63:0] o;
        logic [31:0] oi;
        // Word 0x48 is handed over in the same cycle the redirect is taken.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'd1012;
        expect_word(64'h48);
        cycle();
        bus.redirect_valid = 1'b0;
        cycle();
        expect_word(64'd1012);
        cycle();
        expect_word(64'd1016);
        cycle();
        expect_word(64'd1020);
        cycle();
        checks++;
        if (halted !== 1'b1 || bus.if_valid !== 1'b0 || bus.imem_addr !== 64'd1024) begin
            errors++;
            $display("FAIL halt_enter got h=%b v=%b addr=%0d exp 1/0/1024", halted, bus.if_valid, bus.imem_addr);
        end
        cycle();
        checks++;
        if (halted !== 1'b1 || bus.if_valid !== 1'b0 || bus.imem_addr !== 64'd1024) begin
            errors++;
            $display("FAIL halt_hold got h=%b v=%b addr=%0d exp 1/0/1024", halted, bus.if_valid, bus.imem_addr);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h0;
        cycle();
        bus.redirect_valid = 1'b0;
        checks++;
        if (halted !== 1'b0 || bus.if_valid !== 1'b0 || bus.imem_addr !== 64'h0) begin
            errors++;
            $display("FAIL halt_leave got h=%b v=%b addr=%h exp 0/0/0", halted, bus.if_valid, bus.imem_addr);
        end
        cycle();
        checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'h0) begin
            errors++;
            $display("FAIL halt_restart got v=%b pc=%h exp 1/0", bus.if_valid, bus.if_pc);
        end
        // Redirect arriving exactly at end of memory must win over halting.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'd1020;
        expect_word(64'h0);
        cycle();
        bus.redirect_valid = 1'b0;
        cycle();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h100;
        expect_word(64'd1020);
        cycle();
        bus.redirect_valid = 1'b0;
        checks++;
        if (halted !== 1'b0 || bus.if_valid !== 1'b0 || bus.imem_addr !== 64'h100) begin
            errors++;
            $display("FAIL end_vs_redirect got h=%b v=%b addr=%h exp 0/0/100", halted, bus.if_valid, bus.imem_addr);
        end
        cycle();
        checks++;
        if (obs_pc_q.size() != exp_pc_q.size()) begin
            errors++;
            $display("FAIL halt_count got %0d exp %0d", obs_pc_q.size(), exp_pc_q.size());
        end
        while (exp_pc_q.size() > 0 && obs_pc_q.size() > 0) begin
            e = exp_pc_q.pop_front();
            o = obs_pc_q.pop_front();
            oi = obs_instr_q.pop_front();
            checks++;
            if (o !== e || oi !== rom_word(e, 4'd3)) begin
                errors++;
                $display("FAIL halt_word got pc=%h instr=%h exp pc=%h instr=%h", o, oi, e, rom_word(e, 4'd3));
            end
        end
        exp_pc_q.delete(); obs_pc_q.delete(); obs_instr_q.delete();
    endtask

    task automatic test_misalign();
        logic [63:0] e;
        logic [63:0] o;
        logic [31:0] oi;
        checks++;
        if (err_misalign !== 1'b0) begin
            errors++;
            $display("FAIL misalign_clear got %b exp 0", err_misalign);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h22;
        expect_word(64'h100);
        cycle();
        bus.redirect_valid = 1'b0;
        checks++;
        if (err_misalign !== 1'b1 || bus.imem_addr !== 64'h20) begin
            errors++;
            $display("FAIL misalign_set got e=%b addr=%h exp 1/20", err_misalign, bus.imem_addr);
        end
        cycle();
        checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'h20) begin
            errors++;
            $display("FAIL misalign_fetch got v=%b pc=%h exp 1/20", bus.if_valid, bus.if_pc);
        end
        expect_word(64'h20);
        cycle();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h40;
        expect_word(64'h24);
        cycle();
        bus.redirect_valid = 1'b0;
        cycle();
        checks++;
        if (err_misalign !== 1'b1 || bus.if_pc !== 64'h40) begin
            errors++;
            $display("FAIL misalign_sticky got e=%b pc=%h exp 1/40", err_misalign, bus.if_pc);
        end
        checks++;
        if (obs_pc_q.size() != exp_pc_q.size()) begin
            errors++;
            $display("FAIL misalign_count got %0d exp %0d", obs_pc_q.size(), exp_pc_q.size());
        end
        while (exp_pc_q.size() > 0 && obs_pc_q.size() > 0) begin
            e = exp_pc_q.pop_front();
            o = obs_pc_q.pop_front();
            oi = obs_instr_q.pop_front();
            checks++;
            if (o !== e || oi !== rom_word(e, 4'd3)) begin
                errors++;
                $display("FAIL misalign_word got pc=%h instr=%h exp pc=%h instr=%h", o, oi, e, rom_word(e, 4'd3));
            end
        end
        exp_pc_q.delete(); obs_pc_q.delete(); obs_instr_q.delete();
    endtask

    task automatic test_perf();
        logic [31:0] want_f;
        logic [31:0] want_s;
`ifdef FETCH_PERF_CNT_EN
        want_f = 32'(exp_fetches);
        want_s = 32'(exp_stalls);
`else
        want_f = 32'h0;
        want_s = 32'h0;
`endif
        checks++;
        if (perf_fetches !== want_f) begin
            errors++;
            $display("FAIL perf_fetches got %0d exp %0d", perf_fetches, want_f);
        end
        checks++;
        if (perf_stalls !== want_s) begin
            errors++;
            $display("FAIL perf_stalls got %0d exp %0d", perf_stalls, want_s);
        end
        // Asynchronous reset in the middle of a run.
        reset_n = 1'b0;
        #1;
        checks++;
        if (perf_fetches !== 32'h0 || perf_stalls !== 32'h0 || bus.if_valid !== 1'b0 || bus.if_pc !== 64'h0) begin
            errors++;
            $display("FAIL midrun_reset got pf=%0d ps=%0d v=%b pc=%h exp 0/0/0/0", perf_fetches, perf_stalls, bus.if_valid, bus.if_pc);
        end
        checks++;
        if (err_misalign !== 1'b0 || bus.imem_addr !== 64'h0 || bus.imem_test_sel !== 4'h0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset_status got e=%b addr=%h sel=%h h=%b exp 0/0/0/0", err_misalign, bus.imem_addr, bus.imem_test_sel, halted);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        exp_fetches = 0;
        exp_stalls  = 0;
        test_reset();
        test_stream();
        test_redirect();
        test_halt();
        test_misalign();
        test_perf();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
